// File: rtl/streaming_dwc_up.sv
// streaming_dwc_up
//   Upsizing AXI-Stream width converter. Packs RATIO consecutive IN_WIDTH-bit
//   input words into one IN_WIDTH*RATIO-bit output word, little-endian (the
//   first word of a group lands in the LSBs). Holds one packed output word.
//   While that word waits on the downstream FIFO, the converter keeps
//   accepting the first RATIO-1 words of the next group.
// Ports
//   ap_clk, ap_rst_n             clock, async active-low reset
//   in0_V_V_TDATA/TVALID/TREADY  narrow input stream
//   out_V_V_TDATA/TVALID/TREADY  packed output stream
//   partial                      words held in the packing slots, not yet output
module streaming_dwc_up #(
  parameter int IN_WIDTH  = 8,
  parameter int RATIO     = 2,
  localparam int OUT_WIDTH = IN_WIDTH * RATIO,
  localparam int PW        = $clog2(RATIO)
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic [IN_WIDTH-1:0]  in0_V_V_TDATA,
  input  logic                 in0_V_V_TVALID,
  output logic                 in0_V_V_TREADY,
  output logic [OUT_WIDTH-1:0] out_V_V_TDATA,
  output logic                 out_V_V_TVALID,
  input  logic                 out_V_V_TREADY,
  output logic [PW-1:0]        partial
);

  localparam logic [PW-1:0] LAST = PW'(RATIO - 1);

  logic [RATIO-2:0][IN_WIDTH-1:0] slots;
  logic in_acc, out_acc, completes;

  // Only the completing word needs the output register, so only it can stall.
  assign in0_V_V_TREADY = (partial != LAST) | ~out_V_V_TVALID | out_V_V_TREADY;
  assign in_acc    = in0_V_V_TVALID & in0_V_V_TREADY;
  assign out_acc   = out_V_V_TVALID & out_V_V_TREADY;
  assign completes = in_acc & (partial == LAST);

  // Slots are never cleared between groups; the next group overwrites them.
  for (genvar k = 0; k < RATIO - 1; k++) begin : g_slot
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n)
        slots[k] <= '0;
      else if (in_acc && partial == PW'(k))
        slots[k] <= in0_V_V_TDATA;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)
      partial <= '0;
    else if (in_acc)
      partial <= (partial == LAST) ? '0 : partial + 1'b1;
  end

  // A completing word replaces a word being consumed in the same cycle,
  // so valid stays high and the output runs without bubbles.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_V_V_TVALID <= 1'b0;
      out_V_V_TDATA  <= '0;
    end else if (completes) begin
      out_V_V_TVALID <= 1'b1;
      out_V_V_TDATA  <= {in0_V_V_TDATA, slots};
    end else if (out_acc) begin
      out_V_V_TVALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_streaming_dwc_up.sv
// tb_streaming_dwc_up
//   Directed checks on an 8-bit x2 instance (reset, streaming, backpressure,
//   input gaps) and a randomized scoreboard run on a 4-bit x4 instance.
module tb_streaming_dwc_up;

  logic ap_clk = 1'b0;
  logic ap_rst_n = 1'b0;
  always #5 ap_clk = ~ap_clk;

  // instance A: IN_WIDTH=8, RATIO=2
  logic [7:0]  a_data = '0;
  logic        a_vld = 1'b0, a_rdy, a_ordy = 1'b0, a_ovld;
  logic [15:0] a_odata;
  logic [0:0]  a_part;

  // instance B: IN_WIDTH=4, RATIO=4
  logic [3:0]  b_data = '0;
  logic        b_vld = 1'b0, b_rdy, b_ordy = 1'b0, b_ovld;
  logic [15:0] b_odata;
  logic [1:0]  b_part;

  streaming_dwc_up #(.IN_WIDTH(8), .RATIO(2)) dut_a (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .in0_V_V_TDATA(a_data), .in0_V_V_TVALID(a_vld), .in0_V_V_TREADY(a_rdy),
    .out_V_V_TDATA(a_odata), .out_V_V_TVALID(a_ovld), .out_V_V_TREADY(a_ordy),
    .partial(a_part));

  streaming_dwc_up #(.IN_WIDTH(4), .RATIO(4)) dut_b (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .in0_V_V_TDATA(b_data), .in0_V_V_TVALID(b_vld), .in0_V_V_TREADY(b_rdy),
    .out_V_V_TDATA(b_odata), .out_V_V_TVALID(b_ovld), .out_V_V_TREADY(b_ordy),
    .partial(b_part));

  int n_assert = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock step; returns 1 ns after the edge
  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  // offer one word on A for one edge, checking it is accepted
  task automatic push_a(input logic [7:0] d);
    a_vld = 1'b1;
    a_data = d;
    #1;
    chk("push_ready", 32'(a_rdy), 32'd1);
    @(posedge ap_clk);
    #1;
    a_vld = 1'b0;
  endtask

  logic [3:0]  nib_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] held, word;
  int n_in, n_out, cyc;
  logic in_acc, out_acc, stall;

  initial begin
    // ---- 1. reset ----
    repeat (2) @(posedge ap_clk);
    #1;
    chk("rst_valid", 32'(a_ovld), 32'd0);
    chk("rst_data", 32'(a_odata), 32'h0);
    chk("rst_partial", 32'(a_part), 32'd0);
    ap_rst_n = 1'b1;
    chk("post_rst_ready", 32'(a_rdy), 32'd1);
    push_a(8'h33);
    push_a(8'h44);
    chk("pre_valid", 32'(a_ovld), 32'd1);
    chk("pre_data", 32'(a_odata), 32'h4433);
    push_a(8'h55);
    chk("pre_partial", 32'(a_part), 32'd1);
    #2 ap_rst_n = 1'b0;          // mid-cycle, no clock edge
    #1;
    chk("async_valid", 32'(a_ovld), 32'd0);
    chk("async_data", 32'(a_odata), 32'h0);
    chk("async_partial", 32'(a_part), 32'd0);
    #1 ap_rst_n = 1'b1;
    step();
    chk("rel_ready", 32'(a_rdy), 32'd1);
    push_a(8'h11);
    push_a(8'h22);
    chk("rst_out_valid", 32'(a_ovld), 32'd1);
    chk("rst_out_data", 32'(a_odata), 32'h2211);

    // ---- 2. streaming ----
    a_ordy = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      push_a(8'(i));
      chk("str_valid", 32'(a_ovld), 32'((i % 2) == 0));
      if ((i % 2) == 0) chk("str_data", 32'(a_odata), 32'((i << 8) | (i - 1)));
    end
    step();
    chk("str_drain", 32'(a_ovld), 32'd0);

    // ---- 3. backpressure ----
    a_ordy = 1'b0;
    push_a(8'hA1);
    push_a(8'hA2);
    chk("bp_valid", 32'(a_ovld), 32'd1);
    chk("bp_data", 32'(a_odata), 32'hA2A1);
    push_a(8'hA3);
    chk("bp_partial", 32'(a_part), 32'd1);
    chk("bp_hold0", 32'(a_odata), 32'hA2A1);
    a_vld = 1'b1;
    a_data = 8'hA4;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("bp_stall_ready", 32'(a_rdy), 32'd0);
      step();
      chk("bp_hold_data", 32'(a_odata), 32'hA2A1);
      chk("bp_hold_valid", 32'(a_ovld), 32'd1);
      chk("bp_hold_partial", 32'(a_part), 32'd1);
    end
    a_ordy = 1'b1;
    #1;
    chk("bp_release_ready", 32'(a_rdy), 32'd1);
    step();
    a_vld = 1'b0;
    chk("bp_next_valid", 32'(a_ovld), 32'd1);
    chk("bp_next_data", 32'(a_odata), 32'hA4A3);
    chk("bp_next_partial", 32'(a_part), 32'd0);
    step();
    chk("bp_drain", 32'(a_ovld), 32'd0);

    // ---- 4. input gap ----
    push_a(8'h10);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("gap_partial", 32'(a_part), 32'd1);
      chk("gap_valid", 32'(a_ovld), 32'd0);
    end
    push_a(8'h20);
    chk("gap_valid_out", 32'(a_ovld), 32'd1);
    chk("gap_data", 32'(a_odata), 32'h2010);
    step();
    chk("gap_drain", 32'(a_ovld), 32'd0);

    // ---- 5. random valid/ready on B ----
    n_in = 0;
    n_out = 0;
    cyc = 0;
    while (n_in < 10000 && cyc < 60000) begin
      b_vld  = 1'($urandom_range(0, 1));
      b_ordy = 1'($urandom_range(0, 1));
      b_data = 4'($urandom_range(0, 15));
      #1;
      in_acc  = b_vld & b_rdy;
      out_acc = b_ovld & b_ordy;
      stall   = b_ovld & ~b_ordy;
      held    = b_odata;
      if (out_acc) begin
        n_out++;
        if (exp_q.size() == 0) chk("rnd_unexpected_out", 32'(b_odata), 32'hFFFF_FFFF);
        else chk("rnd_data", 32'(b_odata), 32'(exp_q.pop_front()));
      end
      step();
      cyc++;
      if (stall) begin
        chk("rnd_stable_valid", 32'(b_ovld), 32'd1);
        chk("rnd_stable_data", 32'(b_odata), 32'(held));
      end
      if (in_acc) begin
        n_in++;
        nib_q.push_back(b_data);
        if (nib_q.size() == 4) begin
          word = '0;
          for (int k = 0; k < 4; k++) word = word | (16'(nib_q[k]) << (4 * k));
          exp_q.push_back(word);
          nib_q.delete();
        end
      end
    end
    chk("rnd_in_count", 32'(n_in), 32'd10000);
    b_vld  = 1'b0;
    b_ordy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (b_ovld) begin
        n_out++;
        if (exp_q.size() == 0) chk("rnd_unexpected_out", 32'(b_odata), 32'hFFFF_FFFF);
        else chk("rnd_data", 32'(b_odata), 32'(exp_q.pop_front()));
      end
      step();
    end
    chk("rnd_out_count", 32'(n_out), 32'(n_in / 4));
    chk("rnd_partial_end", 32'(b_part), 32'(n_in % 4));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
